// File: rtl/return_stack_pkg.sv
// Shared constants and CALL/RET operation encoding for the return-address stack.
package return_stack_pkg;

  localparam int unsigned PC_WIDTH    = 10;
  localparam int unsigned STACK_DEPTH = 8;

  // Encoding is {push, pop} as driven by the control unit.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/return_stack_ptr.sv
// Saturating up/down occupancy counter for the return stack; owns count, empty and full.
module stack_ptr #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CW'(DEPTH)) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/return_stack.sv
// LIFO of return addresses: CALL pushes PC+1, RET pops; top entry drives Q with a sticky misuse flag.
module return_stack
  import return_stack_pkg::*;
#(
  parameter  int unsigned WIDTH = PC_WIDTH,
  parameter  int unsigned DEPTH = STACK_DEPTH,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             error
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             error_q, error_d;

  stack_op_e        op;
  logic             inc, dec, wr_en, err_set;
  logic [AW-1:0]    wr_idx, top_idx, cnt_idx;

  assign top_idx = AW'(count - CW'(1));
  assign cnt_idx = AW'(count);

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (inc),
    .dec   (dec),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    op      = decode_op(push, pop);
    inc     = 1'b0;
    dec     = 1'b0;
    wr_en   = 1'b0;
    err_set = 1'b0;
    wr_idx  = cnt_idx;
    unique case (op)
      OP_IDLE: ;
      OP_PUSH: begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          wr_en = 1'b1;
          inc   = 1'b1;
        end
      end
      OP_POP: begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      OP_REPLACE: begin
        // Empty replace still lands D in slot 0 and counts as an underflow.
        wr_en = 1'b1;
        if (empty) begin
          inc     = 1'b1;
          err_set = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
    endcase
  end

  assign error_d = err_set | (error_q & ~clr_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= D;
      end
      error_q <= error_d;
    end
  end

  assign Q     = empty ? '0 : mem_q[top_idx];
  assign error = error_q;

endmodule
